// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared architectural constants and types for the integer
//                register file: data width, register count, index width and
//                the write-back staging entry.
//  Revision    : 1.0  initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xword_t;
    typedef logic [REG_ADDR_W-1:0] regidx_t;

    // One pending write waiting to be committed to the array.
    typedef struct packed {
        logic    valid;
        regidx_t rd;
        xword_t  data;
    } wb_entry_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_if
//  Description : Write/read bus of the register file.
//                Write side : we, rd, wdata, flush
//                Read side  : rs1, rs2 -> rdata1, rdata2 (combinational)
//                Status     : wb_pending (staging register holds a write)
//                master drives requests, slave (the register file) answers.
//  Revision    : 1.0  initial release
// ============================================================================
interface register_file_if;
    import riscv_pkg::*;

    logic    we;
    regidx_t rd;
    xword_t  wdata;
    logic    flush;
    regidx_t rs1;
    regidx_t rs2;
    xword_t  rdata1;
    xword_t  rdata2;
    logic    wb_pending;

    modport master (
        output we, rd, wdata, flush, rs1, rs2,
        input  rdata1, rdata2, wb_pending
    );

    modport slave (
        input  we, rd, wdata, flush, rs1, rs2,
        output rdata1, rdata2, wb_pending
    );

endinterface : register_file_if
`default_nettype wire

// File: rtl/decoder5to32.sv
`default_nettype none
// ============================================================================
//  Module      : decoder5to32
//  Description : Enabled 5-to-32 one-hot decoder used as the register array
//                write-enable generator.
//                i_en     : global enable, all outputs low when 0
//                i_sel    : register index
//                o_onehot : one-hot write enables
//  Revision    : 1.0  initial release
// ============================================================================
module decoder5to32
    import riscv_pkg::*;
(
    input  wire logic             i_en,
    input  wire regidx_t          i_sel,
    output logic [NREGS-1:0]      o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule : decoder5to32
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module      : register_file
//  Description : 32 x 32-bit integer register file with a one-entry write-back
//                staging register. A write is captured into staging at one
//                edge and committed to the array at the next; reads see the
//                staged value through a bypass. flush drops the staged entry.
//                clk : rising-edge clock
//                rst : synchronous active-high reset
//                bus : register_file_if.slave (write, read and status signals)
//  Revision    : 1.0  initial release
// ============================================================================
module register_file
    import riscv_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    register_file_if.slave  bus
);

    wb_entry_t        r_wb;
    xword_t           r_regs [NREGS];
    logic [NREGS-1:0] w_wen;
    logic             w_capture;
    logic             w_commit_en;
    logic             w_unused_wen0;

    // Writes to x0 are dropped at the door, so staging never targets x0.
    assign w_capture   = bus.we && (bus.rd != '0);
    // A flushed or reset-cancelled entry must never reach the array.
    assign w_commit_en = r_wb.valid & ~bus.flush & ~rst;

    decoder5to32 u_wen_dec (
        .i_en     (w_commit_en),
        .i_sel    (r_wb.rd),
        .o_onehot (w_wen)
    );

    // x0 has no storage update path; its enable is intentionally ignored.
    assign w_unused_wen0 = w_wen[0];

    // Staging register: reloaded every edge, so back-to-back writes commit
    // the old entry and capture the new one in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb <= '0;
        end else begin
            r_wb.valid <= w_capture;
            if (w_capture) begin
                r_wb.rd   <= bus.rd;
                r_wb.data <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        r_regs[0] <= '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (w_wen[i]) begin
                r_regs[i] <= r_wb.data;
            end
        end
    end

    // x0 reads zero; a matching staged entry is newer than the array.
    function automatic xword_t read_port(input regidx_t idx);
        if (idx == '0) begin
            return '0;
        end else if (r_wb.valid && (r_wb.rd == idx)) begin
            return r_wb.data;
        end else begin
            return r_regs[idx];
        end
    endfunction

    always_comb begin
        bus.rdata1 = read_port(bus.rs1);
    end

    always_comb begin
        bus.rdata2 = read_port(bus.rs2);
    end

    assign bus.wb_pending = r_wb.valid;

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file
//  Description : Self-checking bench for register_file. Table-driven rows plus
//                hand-written reset and no-bypass sequences; expected read
//                results are queued when a row is driven and popped after the
//                clock edge that the row targets.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register_file;

    logic clk;
    logic rst;

    register_file_if rf_if ();

    register_file dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        flush;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ep;
        int          tag;
    } exp_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];
    exp_t sbq [$];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check32(input string name, input int tag,
                           input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, exp);
        end
    endtask

    task automatic check1(input string name, input int tag,
                          input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d]: got %b, expected %b", name, tag, act, exp);
        end
    endtask

    task automatic set_idle();
        rf_if.we    = 1'b0;
        rf_if.rd    = '0;
        rf_if.wdata = '0;
        rf_if.flush = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue what should be seen after the edge,
    // then pop and compare once the edge has passed.
    task automatic drive_step(input logic we, input logic [4:0] rd,
                              input logic [31:0] wdata, input logic flush,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic ep, input int tag);
        exp_t e;
        @(negedge clk);
        rf_if.we    = we;
        rf_if.rd    = rd;
        rf_if.wdata = wdata;
        rf_if.flush = flush;
        rf_if.rs1   = rs1;
        rf_if.rs2   = rs2;
        sbq.push_back('{e1: e1, e2: e2, ep: ep, tag: tag});
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL scoreboard_empty[%0d]: got 0 entries, expected 1", tag);
        end else begin
            e = sbq.pop_front();
            check32("rdata1", e.tag, rf_if.rdata1, e.e1);
            check32("rdata2", e.tag, rf_if.rdata2, e.e2);
            check1("wb_pending", e.tag, rf_if.wb_pending, e.ep);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            we  rd  wdata         fl  rs1 rs2 e1            e2            ep
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b1};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b1, 5'd7,  32'h11,       1'b0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h11,       1'b1};
        vecs[5]  = '{1'b1, 5'd7,  32'h22,       1'b0, 5'd7, 5'd7, 32'h22,       32'h22,       1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd7, 5'd7, 32'h22,       32'h22,       1'b0};
        vecs[7]  = '{1'b1, 5'd9,  32'h1234,     1'b0, 5'd9, 5'd7, 32'h1234,     32'h22,       1'b1};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd9, 32'h0,        32'h0,        1'b0};
        vecs[9]  = '{1'b1, 5'd4,  32'hA,        1'b0, 5'd4, 5'd6, 32'hA,        32'h0,        1'b1};
        vecs[10] = '{1'b1, 5'd6,  32'hB,        1'b1, 5'd4, 5'd6, 32'h0,        32'hB,        1'b1};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd6, 5'd4, 32'hB,        32'h0,        1'b0};
        vecs[12] = '{1'b1, 5'd1,  32'h100,      1'b0, 5'd1, 5'd2, 32'h100,      32'h0,        1'b1};
        vecs[13] = '{1'b1, 5'd2,  32'h200,      1'b0, 5'd1, 5'd2, 32'h100,      32'h200,      1'b1};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd2, 5'd1, 32'h200,      32'h100,      1'b0};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd31, 5'd5, 32'h0,       32'hDEADBEEF, 1'b0};

        rst = 1'b1;
        set_idle();
        rf_if.rs1 = 5'd5;
        rf_if.rs2 = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        check1("reset_pending", 0, rf_if.wb_pending, 1'b0);
        check32("reset_rdata1", 0, rf_if.rdata1, 32'h0);
        check32("reset_rdata2", 0, rf_if.rdata2, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < NVEC; v++) begin
            drive_step(vecs[v].we, vecs[v].rd, vecs[v].wdata, vecs[v].flush,
                       vecs[v].rs1, vecs[v].rs2, vecs[v].e1, vecs[v].e2,
                       vecs[v].ep, 100 + v);
        end

        // Current-cycle write inputs must not reach the read ports.
        @(negedge clk);
        rf_if.we    = 1'b1;
        rf_if.rd    = 5'd12;
        rf_if.wdata = 32'h5A5A5A5A;
        rf_if.flush = 1'b0;
        rf_if.rs1   = 5'd12;
        rf_if.rs2   = 5'd12;
        #1;
        check32("no_bypass_rdata1", 200, rf_if.rdata1, 32'h0);
        check1("no_bypass_pending", 200, rf_if.wb_pending, 1'b0);
        @(posedge clk);
        #1;
        check32("staged_rdata2", 201, rf_if.rdata2, 32'h5A5A5A5A);
        @(negedge clk);
        set_idle();

        // Fill x1..x31 with index * 0x01010101.
        for (int i = 1; i < 32; i++) begin
            drive_step(1'b1, 5'(i), 32'(i) * 32'h01010101, 1'b0,
                       5'(i), 5'(i - 1),
                       32'(i) * 32'h01010101, 32'(i - 1) * 32'h01010101,
                       1'b1, 300 + i);
        end
        drive_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd31, 5'd30,
                   32'h1F1F1F1F, 32'h1E1E1E1E, 1'b0, 340);
        for (int i = 0; i < 32; i++) begin
            rf_if.rs1 = 5'(i);
            rf_if.rs2 = 5'(31 - i);
            #1;
            check32("fill_rdata1", 400 + i, rf_if.rdata1, 32'(i) * 32'h01010101);
            check32("fill_rdata2", 400 + i, rf_if.rdata2, 32'(31 - i) * 32'h01010101);
        end

        // Stage a write to x3, then reset with a concurrent write and flush.
        drive_step(1'b1, 5'd3, 32'hCAFEF00D, 1'b0, 5'd3, 5'd2,
                   32'hCAFEF00D, 32'h02020202, 1'b1, 500);
        @(negedge clk);
        rst         = 1'b1;
        rf_if.we    = 1'b1;
        rf_if.rd    = 5'd8;
        rf_if.wdata = 32'h99;
        rf_if.flush = 1'b1;
        @(posedge clk);
        #1;
        check1("rst_pending", 501, rf_if.wb_pending, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();
        for (int i = 0; i < 32; i++) begin
            rf_if.rs1 = 5'(i);
            rf_if.rs2 = 5'(31 - i);
            #1;
            check32("post_rst_rdata1", 600 + i, rf_if.rdata1, 32'h0);
            check32("post_rst_rdata2", 600 + i, rf_if.rdata2, 32'h0);
        end

        // First cycle out of reset accepts a write normally.
        drive_step(1'b1, 5'd3, 32'h77, 1'b0, 5'd3, 5'd3, 32'h77, 32'h77, 1'b1, 700);
        drive_step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 5'd8, 32'h77, 32'h0, 1'b0, 701);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port we, input, 1 bit: write request this cycle.
REQ-004 SHALL have port rd, input, 5 bits: destination register index.
REQ-005 SHALL have port wdata, input, 32 bits: write data.
REQ-006 SHALL have port flush, input, 1 bit: cancel the staged, not-yet-committed write.
REQ-007 SHALL have port rs1, input, 5 bits: read port 1 index.
REQ-008 SHALL have port rs2, input, 5 bits: read port 2 index.
REQ-009 SHALL have port rdata1, output, 32 bits: read port 1 data, combinational.
REQ-010 SHALL have port rdata2, output, 32 bits: read port 2 data, combinational.
REQ-011 SHALL have port wb_pending, output, 1 bit: high while the staging register holds an uncommitted write.

Function
REQ-012 SHALL hold 32 x 32-bit registers x0..x31, with x0 reading as 0 at all times.
REQ-013 SHALL capture a write in two stages: edge N (we=1, rd!=0) loads the staging register {wb_valid=1, wb_rd=rd, wb_data=wdata}; edge N+1 commits wb_data to x[wb_rd].
REQ-014 SHALL drive array write enables from a 5-to-32 one-hot decode of wb_rd, gated by wb_valid; at most one register is written per edge.
REQ-015 SHALL leave the staging register invalid when we=1 with rd=0; x0 is never written.
REQ-016 SHALL clear wb_valid at an edge where we=0 (or rd=0), after the pending entry commits.
REQ-017 SHALL, on back-to-back writes, commit the old staged entry and load the new one at the same edge, so sustained throughput is one write per cycle.
REQ-018 SHALL compute rdataX = 0 if rsX=0; otherwise wb_data if wb_valid and wb_rd=rsX; otherwise x[rsX].
REQ-019 SHALL NOT bypass the current-cycle we/rd/wdata inputs to the read ports; those become visible one cycle later, via staging.
REQ-020 SHALL, when flush=1 at an edge, discard the staged entry without committing it; a concurrent we=1, rd!=0 is still captured into staging.
REQ-021 SHALL read identical indices on both ports consistently, with both returning the same value.
REQ-022 SHALL drive wb_pending = wb_valid.

Reset
REQ-023 SHALL, on rst=1 at an edge, clear x1..x31 to 0 and set wb_valid=0, wb_rd=0, wb_data=0; the staged entry is not committed.
REQ-024 SHALL give rst priority over we and flush in the same cycle, with outputs reading 0 for every index in the cycle after reset.
REQ-025 SHALL accept a write presented on the first cycle with rst=0 normally.

Structure
REQ-026 SHALL take XLEN=32, NREGS=32 and REG_ADDR_W=5 from a shared package riscv_pkg.
REQ-027 SHALL instantiate one decoder5to32 (EN=wb_valid & ~flush & ~rst, IN=wb_rd) as the write-enable sub-module.
REQ-028 SHALL implement the read multiplexers and bypass compare inline, without further sub-modules.

Verification
REQ-029 SHALL cover basic write: we=1, rd=5, wdata=0xDEADBEEF at edge 0 -> wb_pending=1 and rdata1(rs1=5)=0xDEADBEEF after edge 0 (bypass); after edge 1, wb_pending=0 and x5=0xDEADBEEF from the array.
REQ-030 SHALL cover x0 write: we=1, rd=0, wdata=0xFFFFFFFF -> wb_pending stays 0 and rdata1(rs1=0)=0 on all cycles.
REQ-031 SHALL cover same-register back-to-back writes: rd=7 with 0x11 then 0x22 on consecutive edges -> rdata2(rs2=7)=0x11 then 0x22; after idle, x7=0x22.
REQ-032 SHALL cover flush: write rd=9, 0x1234, then flush=1 with we=0 on the next edge -> wb_pending=0 and rdata1(rs1=9) returns the old value 0.
REQ-033 SHALL cover reset mid-operation: fill x1..x31 with index*0x01010101 and stage a write to x3, then assert rst for one cycle -> all reads 0 and wb_pending=0.
REQ-034 SHALL cover write plus flush in one cycle: pending rd=4, 0xA; then flush=1, we=1, rd=6, 0xB -> x4 unchanged, staging holds rd=6, and x6=0xB one edge later.
